// File: rtl/ps2_hack_kbd_decoder.sv
// rtl/ps2_hack_kbd_decoder.sv - PS/2 set-2 scan-code decoder producing Hack keyboard codes
module ps2_hack_kbd_decoder #(
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_code_valid,
  input  logic [7:0]  i_code_byte,
  input  logic        i_code_err,
  output logic [15:0] o_kbd_out,
  output logic        o_key_event,
  output logic        o_key_release,
  output logic        o_shift,
  output logic        o_caps
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tmo;
  logic [2:0]      r_pause_cnt;
  logic [7:0]      r_kbd;
  logic [8:0]      r_held;
  logic            r_lshift, r_rshift, r_caps, r_caps_held;
  logic            r_key_event, r_key_release;
  logic            w_fire, w_brk, w_ext;
  logic [7:0]      w_code;

  // Letters follow Shift^Caps; digits follow Shift only; 0 means unmapped.
  function automatic logic [7:0] f_map(input logic ext, input logic [7:0] b,
                                       input logic sh, input logic cp);
    logic [7:0] c;
    c = 8'd0;
    if (ext) begin
      case (b)
        8'h6B: c = 8'd130;  8'h75: c = 8'd131;  8'h74: c = 8'd132;
        8'h72: c = 8'd133;  8'h6C: c = 8'd134;  8'h69: c = 8'd135;
        8'h7D: c = 8'd136;  8'h7A: c = 8'd137;  8'h70: c = 8'd138;
        8'h71: c = 8'd139;
        default: c = 8'd0;
      endcase
    end else begin
      case (b)
        8'h1C: c = 8'd97;   8'h32: c = 8'd98;   8'h21: c = 8'd99;   8'h23: c = 8'd100;
        8'h24: c = 8'd101;  8'h2B: c = 8'd102;  8'h34: c = 8'd103;  8'h33: c = 8'd104;
        8'h43: c = 8'd105;  8'h3B: c = 8'd106;  8'h42: c = 8'd107;  8'h4B: c = 8'd108;
        8'h3A: c = 8'd109;  8'h31: c = 8'd110;  8'h44: c = 8'd111;  8'h4D: c = 8'd112;
        8'h15: c = 8'd113;  8'h2D: c = 8'd114;  8'h1B: c = 8'd115;  8'h2C: c = 8'd116;
        8'h3C: c = 8'd117;  8'h2A: c = 8'd118;  8'h1D: c = 8'd119;  8'h22: c = 8'd120;
        8'h35: c = 8'd121;  8'h1A: c = 8'd122;
        8'h45: c = sh ? 8'd41 : 8'd48;   8'h16: c = sh ? 8'd33 : 8'd49;
        8'h1E: c = sh ? 8'd64 : 8'd50;   8'h26: c = sh ? 8'd35 : 8'd51;
        8'h25: c = sh ? 8'd36 : 8'd52;   8'h2E: c = sh ? 8'd37 : 8'd53;
        8'h36: c = sh ? 8'd94 : 8'd54;   8'h3D: c = sh ? 8'd38 : 8'd55;
        8'h3E: c = sh ? 8'd42 : 8'd56;   8'h46: c = sh ? 8'd40 : 8'd57;
        8'h29: c = 8'd32;   8'h5A: c = 8'd128;  8'h66: c = 8'd129;  8'h76: c = 8'd140;
        8'h05: c = 8'd141;  8'h06: c = 8'd142;  8'h04: c = 8'd143;  8'h0C: c = 8'd144;
        8'h03: c = 8'd145;  8'h0B: c = 8'd146;  8'h83: c = 8'd147;  8'h0A: c = 8'd148;
        8'h01: c = 8'd149;  8'h09: c = 8'd150;  8'h78: c = 8'd151;  8'h07: c = 8'd152;
        default: c = 8'd0;
      endcase
      if (c >= 8'd97 && c <= 8'd122 && (sh ^ cp)) c = c - 8'd32;
    end
    return c;
  endfunction

  always_comb begin
    w_fire = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    if (i_code_valid && !i_code_err) begin
      case (r_state)
        S_IDLE:    w_fire = (i_code_byte != 8'hE0) && (i_code_byte != 8'hF0) && (i_code_byte != 8'hE1);
        S_EXT:     begin w_fire = (i_code_byte != 8'hF0); w_ext = 1'b1; end
        S_BRK:     begin w_fire = 1'b1; w_brk = 1'b1; end
        S_EXT_BRK: begin w_fire = 1'b1; w_brk = 1'b1; w_ext = 1'b1; end
        default:   w_fire = 1'b0;
      endcase
    end
    w_code = f_map(w_ext, i_code_byte, r_lshift | r_rshift, r_caps);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_tmo         <= '0;
      r_pause_cnt   <= '0;
      r_kbd         <= '0;
      r_held        <= '0;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_caps        <= 1'b0;
      r_caps_held   <= 1'b0;
      r_key_event   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_event   <= 1'b0;
      r_key_release <= 1'b0;

      if (i_code_valid) begin
        r_tmo <= '0;
        if (i_code_err) begin
          r_state <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (i_code_byte == 8'hE0) r_state <= S_EXT;
              else if (i_code_byte == 8'hF0) r_state <= S_BRK;
              else if (i_code_byte == 8'hE1) begin
                r_state     <= S_PAUSE;
                r_pause_cnt <= '0;
              end
            end
            S_EXT:   r_state <= (i_code_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
            S_PAUSE: begin
              if (r_pause_cnt == 3'd6) r_state <= S_IDLE;
              else r_pause_cnt <= r_pause_cnt + 3'd1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end else if (r_state != S_IDLE) begin
        if (r_tmo == TMO_LAST) begin
          r_state <= S_IDLE;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end

      // Extended 12/7C map to 0 and so fall through as ignored keys.
      if (w_fire) begin
        if (!w_ext && i_code_byte == 8'h12) r_lshift <= !w_brk;
        else if (!w_ext && i_code_byte == 8'h59) r_rshift <= !w_brk;
        else if (!w_ext && i_code_byte == 8'h58) begin
          if (!w_brk) begin
            if (!r_caps_held) r_caps <= !r_caps;
            r_caps_held <= 1'b1;
          end else begin
            r_caps_held <= 1'b0;
          end
        end else if (w_code != 8'd0) begin
          if (!w_brk) begin
            r_kbd       <= w_code;
            r_held      <= {w_ext, i_code_byte};
            r_key_event <= 1'b1;
          end else if (r_held == {w_ext, i_code_byte}) begin
            r_kbd         <= '0;
            r_held        <= '0;
            r_key_event   <= 1'b1;
            r_key_release <= 1'b1;
          end
        end
      end
    end
  end

  assign o_kbd_out     = {8'h00, r_kbd};
  assign o_key_event   = r_key_event;
  assign o_key_release = r_key_release;
  assign o_shift       = r_lshift | r_rshift;
  assign o_caps        = r_caps;
endmodule

// File: tb/tb_ps2_hack_kbd_decoder.sv
// tb/tb_ps2_hack_kbd_decoder.sv - randomized self-checking bench with a sequence-level reference model
module tb_ps2_hack_kbd_decoder;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  code_byte = 8'h00;
  logic        code_err = 1'b0;
  logic [15:0] kbd_out;
  logic        key_event, key_release, shift, caps;

  int n_vec = 0;
  int n_bad = 0;

  ps2_hack_kbd_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(code_valid), .i_code_byte(code_byte),
    .i_code_err(code_err), .o_kbd_out(kbd_out), .o_key_event(key_event),
    .o_key_release(key_release), .o_shift(shift), .o_caps(caps)
  );

  always #5 clk = ~clk;

  logic [7:0] lt_tab [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                             8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                             8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dg_tab [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  int         dg_sh  [10] = '{41,33,64,35,36,37,94,38,42,40};
  logic [7:0] fk_tab [12] = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
  logic [7:0] ex_tab [10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
  logic [7:0] pool[$];

  logic [7:0] pend[$];
  bit m_lsh, m_rsh, m_caps, m_caps_held, exp_ev, exp_rel;
  int m_held, m_kbd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lookup(bit ext, logic [7:0] b);
    bit sh;
    sh = m_lsh | m_rsh;
    if (ext) begin
      foreach (ex_tab[i]) if (ex_tab[i] == b) return 130 + i;
      return 0;
    end
    foreach (lt_tab[i]) if (lt_tab[i] == b) return ((sh ^ m_caps) ? 65 : 97) + i;
    foreach (dg_tab[i]) if (dg_tab[i] == b) return sh ? dg_sh[i] : 48 + i;
    foreach (fk_tab[i]) if (fk_tab[i] == b) return 141 + i;
    case (b)
      8'h29: return 32;
      8'h5A: return 128;
      8'h66: return 129;
      8'h76: return 140;
      default: return 0;
    endcase
  endfunction

  function automatic void m_reset();
    pend.delete();
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0;
    m_held = -1; m_kbd = 0; exp_ev = 0; exp_rel = 0;
  endfunction

  function automatic void apply(bit brk, bit ext, logic [7:0] b);
    int code, id;
    id = ext * 256 + int'(b);
    if (!ext && b == 8'h12) m_lsh = !brk;
    else if (!ext && b == 8'h59) m_rsh = !brk;
    else if (!ext && b == 8'h58) begin
      if (!brk) begin
        if (!m_caps_held) m_caps = !m_caps;
        m_caps_held = 1;
      end else m_caps_held = 0;
    end else begin
      code = lookup(ext, b);
      if (code != 0) begin
        if (!brk) begin
          m_kbd = code; m_held = id; exp_ev = 1;
        end else if (m_held == id) begin
          m_kbd = 0; m_held = -1; exp_ev = 1; exp_rel = 1;
        end
      end
    end
  endfunction

  // Bytes are buffered until they form a complete set-2 sequence, then interpreted.
  function automatic void model_byte(logic [7:0] b, bit err);
    exp_ev = 0; exp_rel = 0;
    if (err) begin pend.delete(); return; end
    if (pend.size() > 0 && pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) pend.delete();
    end else if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
      else apply(0, 0, b);
    end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
      if (b == 8'hF0) pend.push_back(b);
      else begin apply(0, 1, b); pend.delete(); end
    end else begin
      apply(1, pend[0] == 8'hE0, b);
      pend.delete();
    end
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_kbd"}, kbd_out, m_kbd);
    check({tag, "_ev"}, key_event, exp_ev);
    check({tag, "_rel"}, key_release, exp_rel);
    check({tag, "_shift"}, shift, m_lsh | m_rsh);
    check({tag, "_caps"}, caps, m_caps);
  endtask

  task automatic send(input logic [7:0] b, input bit err = 0);
    code_byte = b; code_err = err; code_valid = 1'b1;
    model_byte(b, err);
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0; code_err = 1'b0;
    check_outs($sformatf("byte%02h", b));
  endtask

  task automatic idle(input int n);
    if (n >= TMO) pend.delete();
    exp_ev = 0; exp_rel = 0;
    repeat (n) @(negedge clk);
    if (n > 0) check("idle_pulse", {key_event, key_release}, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int r;
    logic [7:0] rb;
    foreach (lt_tab[i]) pool.push_back(lt_tab[i]);
    foreach (dg_tab[i]) pool.push_back(dg_tab[i]);
    foreach (fk_tab[i]) pool.push_back(fk_tab[i]);
    pool.push_back(8'h29); pool.push_back(8'h5A); pool.push_back(8'h66); pool.push_back(8'h76);
    pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h58);

    @(negedge clk);
    do_reset();

    send(8'h1C); check("dir_a_make", {kbd_out, key_event}, {16'd97, 1'b1});
    send(8'hF0); send(8'h1C);
    check("dir_a_break", {kbd_out, key_event, key_release}, {16'd0, 2'b11});

    send(8'h12); check("dir_shift_on", shift, 1'b1);
    send(8'h1C); check("dir_A", kbd_out, 16'd65);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("dir_shift_off", shift, 1'b0);

    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    check("dir_caps_A", {caps, kbd_out}, {1'b1, 16'd65});
    send(8'hF0); send(8'h1C);
    send(8'h58); send(8'h58); send(8'h58);
    check("dir_caps_repeat", caps, 1'b0);
    send(8'hF0); send(8'h58);

    send(8'hE0); send(8'h75); check("dir_up", kbd_out, 16'd131);
    send(8'hE0); send(8'hF0); send(8'h75); check("dir_up_rel", kbd_out, 16'd0);

    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
    check("dir_old_break", {kbd_out, key_event}, {16'd98, 1'b0});
    send(8'hF0); send(8'h32); check("dir_b_rel", kbd_out, 16'd0);

    send(8'hE0); idle(TMO + 5); send(8'h75);
    check("dir_timeout", {kbd_out, key_event}, {16'd0, 1'b0});
    send(8'hE0); idle(TMO - 5); send(8'h75);
    check("dir_no_timeout", kbd_out, 16'd131);
    send(8'hE0); send(8'hF0); send(8'h75);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h29); check("dir_pause_space", kbd_out, 16'd32);

    send(8'h1C); send(8'hE0);
    #2 rst_n = 1'b0; m_reset();
    #1 check("dir_async_rst", {kbd_out, key_event, key_release, shift, caps}, 20'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    send(8'h72); check("dir_after_rst", kbd_out, 16'd0);

    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 45) send(pool[$urandom_range(0, pool.size() - 1)]);
      else if (r < 55) begin send(8'hE0); send(ex_tab[$urandom_range(0, 9)]); end
      else if (r < 65) begin
        if (m_held >= 0) begin
          if (m_held >= 256) send(8'hE0);
          send(8'hF0); rb = 8'(m_held); send(rb);
        end else begin
          send(8'hF0); send(pool[$urandom_range(0, pool.size() - 1)]);
        end
      end
      else if (r < 72) begin send(8'hF0); send(pool[$urandom_range(0, pool.size() - 1)]); end
      else if (r < 75) send(8'hE1);
      else if (r < 80) send(8'($urandom));
      else if (r < 82) send(8'($urandom), 1);
      else if (r < 84) idle(TMO + 3);
      else if (r < 87) send((r & 1) ? 8'hE0 : 8'hF0);
      else idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
